// File: rtl/iter_alu.sv
// Multi-cycle ALU: single-cycle logic/compare ops, iterative shift-add multiply and restoring divide.
// All state advances on the falling edge of Fast_Clock; handshakes on both sides allow the pipeline to stall.
module iter_alu #(
    parameter int WIDTH      = 32,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic             Fast_Clock,
    input  logic             Reset,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [4:0]       ALU_Op,
    input  logic [WIDTH-1:0] Data_1,
    input  logic [WIDTH-1:0] Data_2,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Result,
    output logic             True,
    output logic             Div_Zero,
    output logic             Busy
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_LAST  = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_MUL = 5'd2,  OP_DIV = 5'd3;
    localparam logic [4:0] OP_MOD = 5'd4,  OP_AND = 5'd5,  OP_OR  = 5'd6,  OP_XOR = 5'd7;
    localparam logic [4:0] OP_NOT = 5'd8,  OP_SHL = 5'd9,  OP_SHR = 5'd10, OP_EQ  = 5'd11;
    localparam logic [4:0] OP_NE  = 5'd12, OP_GE  = 5'd13, OP_GT  = 5'd14, OP_LE  = 5'd15;
    localparam logic [4:0] OP_LT  = 5'd16, OP_IMM = 5'd18;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MUL_IT = 2'd1,
        S_DIV_IT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state, w_state_nx;
    logic [4:0]       r_op, w_op_nx;
    logic [WIDTH-1:0] r_a, w_a_nx;      // multiplier (shifts right) / dividend-quotient (shifts left)
    logic [WIDTH-1:0] r_b, w_b_nx;      // multiplicand (shifts left) / divisor
    logic [WIDTH-1:0] r_acc, w_acc_nx;  // product accumulator / partial remainder
    logic [CW-1:0]    r_cnt, w_cnt_nx;
    logic [WIDTH-1:0] r_result, w_result_nx;
    logic             r_true, w_true_nx;
    logic             r_div_zero, w_div_zero_nx;
    logic             r_out_valid, w_out_valid_nx;

    logic [WIDTH-1:0] w_fast_result;
    logic             w_fast_true;
    logic             w_is_cmp;
    logic             w_lt;
    logic             w_eq;
    logic [WIDTH-1:0] w_mul_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_q_bit;

    // Single-cycle result for the op currently on the input port.
    always_comb begin
        w_fast_result = {WIDTH{1'b0}};
        w_fast_true   = 1'b0;
        w_is_cmp      = 1'b0;
        w_eq          = (Data_1 == Data_2);
        if (SIGNED_CMP) begin
            w_lt = ($signed(Data_1) < $signed(Data_2));
        end else begin
            w_lt = (Data_1 < Data_2);
        end
        case (ALU_Op)
            OP_ADD: w_fast_result = Data_1 + Data_2;
            OP_SUB: w_fast_result = Data_1 - Data_2;
            OP_AND: w_fast_result = Data_1 & Data_2;
            OP_OR:  w_fast_result = Data_1 | Data_2;
            OP_XOR: w_fast_result = Data_1 ^ Data_2;
            OP_NOT: w_fast_result = ~Data_1;
            OP_SHL: w_fast_result = (Data_2 >= SHIFT_LIM) ? {WIDTH{1'b0}} : (Data_1 << Data_2);
            OP_SHR: w_fast_result = (Data_2 >= SHIFT_LIM) ? {WIDTH{1'b0}} : (Data_1 >> Data_2);
            OP_EQ:  begin w_is_cmp = 1'b1; w_fast_true = w_eq;           end
            OP_NE:  begin w_is_cmp = 1'b1; w_fast_true = !w_eq;          end
            OP_GE:  begin w_is_cmp = 1'b1; w_fast_true = !w_lt;          end
            OP_GT:  begin w_is_cmp = 1'b1; w_fast_true = !w_lt && !w_eq; end
            OP_LE:  begin w_is_cmp = 1'b1; w_fast_true = w_lt || w_eq;   end
            OP_LT:  begin w_is_cmp = 1'b1; w_fast_true = w_lt;           end
            OP_IMM: w_fast_result = Data_2;
            default: w_fast_result = {WIDTH{1'b0}};
        endcase
        if (w_is_cmp) begin
            w_fast_result = {{(WIDTH-1){1'b0}}, w_fast_true};
        end else begin
            w_fast_result = w_fast_result;
        end
    end

    // FSM next-state and iterative datapath step.
    always_comb begin
        w_state_nx     = r_state;
        w_op_nx        = r_op;
        w_a_nx         = r_a;
        w_b_nx         = r_b;
        w_acc_nx       = r_acc;
        w_cnt_nx       = r_cnt;
        w_result_nx    = r_result;
        w_true_nx      = r_true;
        w_div_zero_nx  = r_div_zero;
        w_out_valid_nx = r_out_valid;
        w_mul_sum      = r_acc + r_b;
        w_rem_sh       = {r_acc, r_a[WIDTH-1]};
        w_diff         = w_rem_sh - {1'b0, r_b};
        w_q_bit        = ~w_diff[WIDTH];  // no borrow: divisor fits into shifted remainder
        case (r_state)
            S_IDLE: begin
                if (In_Valid) begin
                    w_op_nx       = ALU_Op;
                    w_a_nx        = Data_1;
                    w_b_nx        = Data_2;
                    w_acc_nx      = {WIDTH{1'b0}};
                    w_cnt_nx      = {CW{1'b0}};
                    w_true_nx     = 1'b0;
                    w_div_zero_nx = 1'b0;
                    if (ALU_Op == OP_MUL) begin
                        w_state_nx = S_MUL_IT;
                    end else if ((ALU_Op == OP_DIV) || (ALU_Op == OP_MOD)) begin
                        if (Data_2 == {WIDTH{1'b0}}) begin
                            w_result_nx    = (ALU_Op == OP_DIV) ? {WIDTH{1'b1}} : Data_1;
                            w_div_zero_nx  = 1'b1;
                            w_out_valid_nx = 1'b1;
                            w_state_nx     = S_DONE;
                        end else begin
                            w_state_nx = S_DIV_IT;
                        end
                    end else begin
                        w_result_nx    = w_fast_result;
                        w_true_nx      = w_fast_true;
                        w_out_valid_nx = 1'b1;
                        w_state_nx     = S_DONE;
                    end
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_MUL_IT: begin
                w_acc_nx = r_a[0] ? w_mul_sum : r_acc;
                w_a_nx   = r_a >> 1;
                w_b_nx   = r_b << 1;
                w_cnt_nx = r_cnt + CNT_ONE;
                if (r_cnt == CNT_LAST) begin
                    w_result_nx    = w_acc_nx;
                    w_out_valid_nx = 1'b1;
                    w_state_nx     = S_DONE;
                end else begin
                    w_state_nx = S_MUL_IT;
                end
            end
            S_DIV_IT: begin
                w_acc_nx = w_q_bit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
                w_a_nx   = {r_a[WIDTH-2:0], w_q_bit};
                w_cnt_nx = r_cnt + CNT_ONE;
                if (r_cnt == CNT_LAST) begin
                    w_result_nx    = (r_op == OP_DIV) ? w_a_nx : w_acc_nx;
                    w_out_valid_nx = 1'b1;
                    w_state_nx     = S_DONE;
                end else begin
                    w_state_nx = S_DIV_IT;
                end
            end
            S_DONE: begin
                if (Out_Ready) begin
                    w_out_valid_nx = 1'b0;
                    w_state_nx     = S_IDLE;
                end else begin
                    w_state_nx = S_DONE;
                end
            end
            default: begin
                w_out_valid_nx = 1'b0;
                w_state_nx     = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, falling-edge clocked.
    always_ff @(negedge Fast_Clock or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_op        <= 5'd0;
            r_a         <= {WIDTH{1'b0}};
            r_b         <= {WIDTH{1'b0}};
            r_acc       <= {WIDTH{1'b0}};
            r_cnt       <= {CW{1'b0}};
            r_result    <= {WIDTH{1'b0}};
            r_true      <= 1'b0;
            r_div_zero  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_op        <= w_op_nx;
            r_a         <= w_a_nx;
            r_b         <= w_b_nx;
            r_acc       <= w_acc_nx;
            r_cnt       <= w_cnt_nx;
            r_result    <= w_result_nx;
            r_true      <= w_true_nx;
            r_div_zero  <= w_div_zero_nx;
            r_out_valid <= w_out_valid_nx;
        end
    end

    assign In_Ready  = (r_state == S_IDLE);
    assign Busy      = (r_state == S_MUL_IT) || (r_state == S_DIV_IT);
    assign Out_Valid = r_out_valid;
    assign Result    = r_result;
    assign True      = r_true;
    assign Div_Zero  = r_div_zero;

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu: unsigned and signed-compare instances run in lockstep against
// an arithmetic reference model, with directed corner cases, backpressure, reset abort and random ops.
module tb_iter_alu;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [4:0]  alu_op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        out_ready;

    logic        u_in_ready, u_out_valid, u_true, u_div_zero, u_busy;
    logic [31:0] u_result;
    logic        s_in_ready, s_out_valid, s_true, s_div_zero, s_busy;
    logic [31:0] s_result;

    int checks = 0;
    int errors = 0;

    iter_alu #(.WIDTH(32), .SIGNED_CMP(1'b0)) dut_u (
        .Fast_Clock(clk), .Reset(rst), .In_Valid(in_valid), .In_Ready(u_in_ready),
        .ALU_Op(alu_op), .Data_1(d1), .Data_2(d2), .Out_Valid(u_out_valid),
        .Out_Ready(out_ready), .Result(u_result), .True(u_true), .Div_Zero(u_div_zero),
        .Busy(u_busy)
    );

    iter_alu #(.WIDTH(32), .SIGNED_CMP(1'b1)) dut_s (
        .Fast_Clock(clk), .Reset(rst), .In_Valid(in_valid), .In_Ready(s_in_ready),
        .ALU_Op(alu_op), .Data_1(d1), .Data_2(d2), .Out_Valid(s_out_valid),
        .Out_Ready(out_ready), .Result(s_result), .True(s_true), .Div_Zero(s_div_zero),
        .Busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference behaviour straight from the op table.
    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input bit sg, output logic [31:0] r, output logic t,
                                  output logic dz, output int lat);
        logic lt;
        r = 32'd0; t = 1'b0; dz = 1'b0; lat = 1;
        lt = sg ? ($signed(a) < $signed(b)) : (a < b);
        case (op)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  begin r = a * b; lat = 33; end
            5'd3:  if (b == 32'd0) begin r = 32'hFFFF_FFFF; dz = 1'b1; end
                   else begin r = a / b; lat = 33; end
            5'd4:  if (b == 32'd0) begin r = a; dz = 1'b1; end
                   else begin r = a % b; lat = 33; end
            5'd5:  r = a & b;
            5'd6:  r = a | b;
            5'd7:  r = a ^ b;
            5'd8:  r = ~a;
            5'd9:  r = (b >= 32'd32) ? 32'd0 : (a << b[4:0]);
            5'd10: r = (b >= 32'd32) ? 32'd0 : (a >> b[4:0]);
            5'd11: t = (a == b);
            5'd12: t = (a != b);
            5'd13: t = !lt;
            5'd14: t = !lt && (a != b);
            5'd15: t = lt || (a == b);
            5'd16: t = lt;
            5'd18: r = b;
            default: r = 32'd0;
        endcase
        if (op >= 5'd11 && op <= 5'd16) r = {31'd0, t};
    endfunction

    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] ur, sr;
        logic ut, st, udz, sdz;
        int el, sl, n, busy_n;
        model(op, a, b, 1'b0, ur, ut, udz, el);
        model(op, a, b, 1'b1, sr, st, sdz, sl);
        @(posedge clk);
        in_valid = 1'b1; alu_op = op; d1 = a; d2 = b; out_ready = 1'b0;
        #1;
        check1({tag, ":in_ready"}, u_in_ready, 1'b1);
        @(posedge clk);
        in_valid = 1'b0;
        n = 1;
        busy_n = 0;
        while (!u_out_valid && n < 100) begin
            if (u_busy) busy_n++;
            @(posedge clk);
            n++;
        end
        check32({tag, ":latency"}, n, el);
        check32({tag, ":busy_cycles"}, busy_n, el - 1);
        check32({tag, ":result_u"}, u_result, ur);
        check1({tag, ":true_u"}, u_true, ut);
        check1({tag, ":divz_u"}, u_div_zero, udz);
        check1({tag, ":valid_s"}, s_out_valid, 1'b1);
        check32({tag, ":result_s"}, s_result, sr);
        check1({tag, ":true_s"}, s_true, st);
        check1({tag, ":divz_s"}, s_div_zero, sdz);
        out_ready = 1'b1;
        @(posedge clk);
        out_ready = 1'b0;
        check1({tag, ":valid_drop"}, u_out_valid, 1'b0);
        check1({tag, ":ready_back"}, u_in_ready, 1'b1);
    endtask

    initial begin
        logic [4:0]  rop;
        logic [31:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; alu_op = 5'd0; d1 = 32'd0; d2 = 32'd0; out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        check1("rst:out_valid", u_out_valid, 1'b0);
        check1("rst:in_ready", u_in_ready, 1'b1);
        check1("rst:busy", u_busy, 1'b0);
        check32("rst:result", u_result, 32'd0);
        check1("rst:true", u_true, 1'b0);
        check1("rst:div_zero", u_div_zero, 1'b0);
        rst = 1'b0;

        run_op("add", 5'd0, 32'd5, 32'd3);
        run_op("sub", 5'd1, 32'd3, 32'd5);
        run_op("mul", 5'd2, 32'h0000_FFFF, 32'h0001_0001);
        run_op("div", 5'd3, 32'd100, 32'd7);
        run_op("mod", 5'd4, 32'd100, 32'd7);
        run_op("div0", 5'd3, 32'd5, 32'd0);
        run_op("mod0", 5'd4, 32'd5, 32'd0);
        run_op("lt_neg", 5'd16, 32'hFFFF_FFFF, 32'd1);
        run_op("ge_neg", 5'd13, 32'h8000_0000, 32'h7FFF_FFFF);
        run_op("shl40", 5'd9, 32'd1, 32'd40);
        run_op("shl31", 5'd9, 32'd1, 32'd31);
        run_op("shr32", 5'd10, 32'h8000_0000, 32'd32);
        run_op("op25", 5'd25, 32'h1234_5678, 32'h9ABC_DEF0);
        run_op("nop", 5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("imm", 5'd18, 32'd0, 32'hCAFE_F00D);
        run_op("div_max", 5'd3, 32'hFFFF_FFFF, 32'd1);
        run_op("mod_big", 5'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        // Backpressure: result held and new requests refused while the consumer stalls.
        @(posedge clk);
        in_valid = 1'b1; alu_op = 5'd0; d1 = 32'd20; d2 = 32'd22;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            alu_op = 5'd18; d2 = 32'd100 + 32'(i);
            check1("bp:valid", u_out_valid, 1'b1);
            check32("bp:result", u_result, 32'd42);
            check1("bp:in_ready", u_in_ready, 1'b0);
            @(posedge clk);
        end
        check32("bp:result_end", u_result, 32'd42);
        alu_op = 5'd18; d2 = 32'h0000_0055; out_ready = 1'b1;
        @(posedge clk);
        out_ready = 1'b0;
        check1("bp:release_valid", u_out_valid, 1'b0);
        check1("bp:release_ready", u_in_ready, 1'b1);
        @(posedge clk);
        in_valid = 1'b0;
        check1("bp:next_valid", u_out_valid, 1'b1);
        check32("bp:next_result", u_result, 32'h0000_0055);
        out_ready = 1'b1;
        @(posedge clk);
        out_ready = 1'b0;

        // Reset in the middle of a divide discards it.
        @(posedge clk);
        in_valid = 1'b1; alu_op = 5'd3; d1 = 32'd1000; d2 = 32'd7;
        @(posedge clk);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        check1("rst_mid:busy_before", u_busy, 1'b1);
        rst = 1'b1;
        #1;
        check1("rst_mid:out_valid", u_out_valid, 1'b0);
        check1("rst_mid:in_ready", u_in_ready, 1'b1);
        check1("rst_mid:busy", u_busy, 1'b0);
        check32("rst_mid:result", u_result, 32'd0);
        @(posedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        check1("rst_mid:no_result", u_out_valid, 1'b0);
        run_op("rst_add", 5'd0, 32'd1, 32'd1);

        // Random ops, biased toward the iterative ones and toward boundary operands.
        for (int k = 0; k < 40; k++) begin
            rop = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0) rop = 5'($urandom_range(2, 4));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = 32'($urandom_range(0, 40));
                2: rb = 32'd0;
                default: rb = ra;
            endcase
            run_op($sformatf("rnd%0d_op%0d", k, rop), rop, ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
